// File: rtl/delay_share_arb.sv
// delay_share_arb: round-robin sharing of one fixed-latency delay line among NCH channels
module delay_share_arb #(
    parameter int NCH  = 4,
    parameter int BWID = 8,
    parameter int LAT  = 32,
    parameter int CHW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*BWID-1:0] iv_req_data,
    input  logic [NCH-1:0]      iv_req_valid,
    output logic [NCH-1:0]      ov_req_ready,
    input  logic [NCH-1:0]      iv_ch_en,
    input  logic                i_hold,
    output logic [BWID-1:0]     ov_pipe_data,
    output logic                o_pipe_nd,
    input  logic [BWID-1:0]     iv_pipe_data,
    input  logic                i_pipe_dv,
    output logic [BWID-1:0]     ov_rsp_data,
    output logic [NCH-1:0]      ov_rsp_valid,
    output logic                o_idle,
    output logic                o_err
);
    logic [CHW-1:0]          ptr;
    logic [CHW-1:0]          gnt_idx;
    logic                    gnt_any;
    logic [NCH-1:0]          elig;
    logic [LAT-1:0]          tv;
    logic [LAT-1:0][CHW-1:0] tt;

    assign elig         = iv_req_valid & iv_ch_en & {NCH{~i_hold}};
    assign ov_req_ready = gnt_any ? (NCH'(1) << gnt_idx) : '0;
    assign o_idle       = ~|tv & ~o_pipe_nd & ~|ov_rsp_valid;

    // first eligible channel at or after ptr, wrapping; lowest offset wins
    always_comb begin
        int c;
        gnt_any = 1'b0;
        gnt_idx = '0;
        c       = 0;
        for (int i = NCH-1; i >= 0; i--) begin
            c = int'(ptr) + i;
            if (c >= NCH) c = c - NCH;
            if (elig[c]) begin
                gnt_any = 1'b1;
                gnt_idx = CHW'(c);
            end
        end
    end

    // issue the granted word into the delay line and advance the pointer past it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            o_pipe_nd    <= 1'b0;
            ov_pipe_data <= '0;
        end else begin
            o_pipe_nd <= gnt_any;
            if (gnt_any) begin
                ov_pipe_data <= iv_req_data[int'(gnt_idx)*BWID +: BWID];
                ptr          <= (gnt_idx == CHW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // owner tags travel alongside the data so stage LAT lines up with i_pipe_dv
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tv <= '0;
            tt <= '0;
        end else begin
            tv[0] <= gnt_any;
            tt[0] <= gnt_any ? gnt_idx : '0;
            for (int i = 1; i < LAT; i++) begin
                tv[i] <= tv[i-1];
                tt[i] <= tt[i-1];
            end
        end
    end

    // route returning words to their owner; untagged or missing words flag o_err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_rsp_data  <= '0;
            ov_rsp_valid <= '0;
            o_err        <= 1'b0;
        end else begin
            if (i_pipe_dv) ov_rsp_data <= iv_pipe_data;
            ov_rsp_valid <= (i_pipe_dv & tv[LAT-1]) ? (NCH'(1) << tt[LAT-1]) : '0;
            if (i_pipe_dv != tv[LAT-1]) o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_delay_share_arb.sv
// tb_delay_share_arb: randomized check of delay_share_arb against a timestamped scoreboard
module tb_delay_share_arb;
    localparam int NCH  = 4;
    localparam int BWID = 8;
    localparam int LAT  = 32;
    localparam int CHW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH*BWID-1:0] iv_req_data = '0;
    logic [NCH-1:0]      iv_req_valid = '0;
    logic [NCH-1:0]      ov_req_ready;
    logic [NCH-1:0]      iv_ch_en = '0;
    logic                i_hold = 1'b0;
    logic [BWID-1:0]     ov_pipe_data;
    logic                o_pipe_nd;
    logic [BWID-1:0]     iv_pipe_data = '0;
    logic                i_pipe_dv = 1'b0;
    logic [BWID-1:0]     ov_rsp_data;
    logic [NCH-1:0]      ov_rsp_valid;
    logic                o_idle;
    logic                o_err;

    delay_share_arb #(.NCH(NCH), .BWID(BWID), .LAT(LAT), .CHW(CHW)) dut (
        .clk(clk), .rst(rst),
        .iv_req_data(iv_req_data), .iv_req_valid(iv_req_valid), .ov_req_ready(ov_req_ready),
        .iv_ch_en(iv_ch_en), .i_hold(i_hold),
        .ov_pipe_data(ov_pipe_data), .o_pipe_nd(o_pipe_nd),
        .iv_pipe_data(iv_pipe_data), .i_pipe_dv(i_pipe_dv),
        .ov_rsp_data(ov_rsp_data), .ov_rsp_valid(ov_rsp_valid),
        .o_idle(o_idle), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [7:0]  d;
        int          due;
    } rec_t;

    rec_t       recs[$];
    logic [8:0] dq[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         mptr = 0;
    logic       e_nd = 0, e_err = 0;
    logic [7:0] e_pd = 0, e_rd = 0;
    logic [3:0] e_rv = 0;
    logic       inj_stray = 0, inj_drop = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // one clock cycle: model the delay line, predict the grant and the next edge
    task automatic tick();
        logic [8:0] e;
        logic       tp;
        int         g;
        e = dq.pop_front();
        dq.push_back({o_pipe_nd, ov_pipe_data});
        if (inj_stray) e = {1'b1, 8'($urandom)};
        if (inj_drop) e[8] = 1'b0;
        i_pipe_dv    = e[8];
        iv_pipe_data = e[7:0];
        #1;
        g = -1;
        if (!i_hold)
            for (int i = 0; i < NCH; i++)
                if (g < 0 && iv_req_valid[(mptr+i)%NCH] && iv_ch_en[(mptr+i)%NCH]) g = (mptr+i)%NCH;
        chk("ready", 32'(ov_req_ready), (g < 0) ? 32'd0 : 32'd1 << g);
        chk("idle", 32'(o_idle), 32'(recs.size() == 0 && e_rv == 0));
        tp = recs.size() > 0 && recs[0].due == cyc;
        if (e[8] != tp) e_err = 1'b1;
        e_rv = (e[8] && tp) ? 4'(1 << recs[0].ch) : 4'd0;
        e_rd = (e[8] && tp) ? recs[0].d : e[8] ? e[7:0] : e_rd;
        if (tp) void'(recs.pop_front());
        e_nd = g >= 0;
        if (g >= 0) begin
            e_pd = iv_req_data[g*BWID +: BWID];
            recs.push_back('{ch: g, d: e_pd, due: cyc + LAT});
            mptr = (g + 1) % NCH;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("pipe_nd", 32'(o_pipe_nd), 32'(e_nd));
        chk("pipe_data", 32'(ov_pipe_data), 32'(e_pd));
        chk("rsp_valid", 32'(ov_rsp_valid), 32'(e_rv));
        chk("rsp_data", 32'(ov_rsp_data), 32'(e_rd));
        chk("err", 32'(o_err), 32'(e_err));
        @(negedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_pipe_data", 32'(ov_pipe_data), 0);
        chk("rst_pipe_nd", 32'(o_pipe_nd), 0);
        chk("rst_rsp_data", 32'(ov_rsp_data), 0);
        chk("rst_rsp_valid", 32'(ov_rsp_valid), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_idle", 32'(o_idle), 1);
        recs.delete();
        mptr = 0; e_nd = 0; e_pd = 0; e_rv = 0; e_rd = 0; e_err = 0;
    endtask

    // asynchronous reset asserted mid-cycle, held across one rising edge
    task automatic rst_pulse();
        #2 rst = 1'b1;
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_data();
        iv_req_data = NCH*BWID'($urandom);
    endtask

    initial begin
        for (int i = 0; i < LAT-1; i++) dq.push_back(9'd0);
        #1 chk_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        iv_req_valid = '1;
        iv_ch_en     = '1;
        for (int k = 0; k < NCH; k++) iv_req_data[k*BWID +: BWID] = 8'(8'h10 + k);
        repeat (80) tick();
        iv_req_valid = 4'b0100;
        repeat (100) begin rand_data(); tick(); end
        iv_req_valid = '1;
        iv_ch_en     = 4'b1010;
        repeat (40) begin rand_data(); tick(); end
        iv_ch_en = '1;
        repeat (32) begin rand_data(); tick(); end
        i_hold = 1'b1;
        repeat (45) begin rand_data(); tick(); end
        i_hold       = 1'b0;
        iv_req_valid = '0;
        repeat (5) tick();
        inj_stray = 1'b1;
        tick();
        inj_stray    = 1'b0;
        iv_req_valid = 4'b0001;
        tick();
        iv_req_valid = '0;
        repeat (40) begin
            inj_drop = recs.size() > 0 && recs[0].due == cyc;
            tick();
        end
        inj_drop = 1'b0;
        rst_pulse();
        iv_req_valid = '1;
        repeat (20) begin rand_data(); tick(); end
        rst_pulse();
        iv_req_valid = '0;
        repeat (40) tick();
        rst_pulse();
        iv_req_valid = '1;
        repeat (3) begin rand_data(); tick(); end
        repeat (200) begin
            rand_data();
            iv_req_valid = 4'($urandom);
            iv_ch_en     = 4'($urandom) | 4'($urandom);
            i_hold       = ($urandom_range(0, 7) == 0);
            tick();
        end
        iv_req_valid = '0;
        i_hold       = 1'b0;
        repeat (40) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
